// File: rtl/bcd_updown_counter_display_pkg.sv
// Shared constants and digit helpers for the multi-digit BCD up/down counter with multiplexed display.
package bcd_disp_pkg;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } bcd_step_t;

  // Counter width for a range of n values; never narrower than 1 bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  function automatic bcd_step_t bcd_inc(input logic [3:0] d, input logic cin);
    bcd_step_t s;
    s = '0;
    if (!cin)              s.digit = d;
    else if (d == BCD_MAX) s.carry = 1'b1;
    else                   s.digit = d + 4'd1;
    return s;
  endfunction

  function automatic bcd_step_t bcd_dec(input logic [3:0] d, input logic bin);
    bcd_step_t s;
    s = '0;
    if (!bin) begin
      s.digit = d;
    end else if (d == 4'd0) begin
      s.carry = 1'b1;
      s.digit = BCD_MAX;
    end else begin
      s.digit = d - 4'd1;
    end
    return s;
  endfunction

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_updown_counter_display_if.sv
// Button inputs and counter/display outputs of the BCD counter, grouped as one bus.
interface bcd_disp_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  pb_up;
  logic                  pb_down;
  logic                  pb_clr;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  wrap;
  logic [6:0]            display;
  logic [DIGITS-1:0]     anode;

  modport master (
    output pb_up, pb_down, pb_clr,
    input  count_bcd, wrap, display, anode
  );

  modport slave (
    input  pb_up, pb_down, pb_clr,
    output count_bcd, wrap, display, anode
  );
endinterface

// File: rtl/bcd_to_seven_segment_decoder.sv
// Single BCD digit to active-low seven-segment pattern; non-BCD codes blank the digit.
module bcd_to_seven_segment_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd_seg(bcd);
endmodule

// File: rtl/bcd_updown_counter_display_debouncer.sv
// Pushbutton conditioning: 2-FF synchronizer, stability counter, one-cycle pulse on accepted press.
module pb_debouncer
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic press
);
  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pb};
      press  <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          press   <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/bcd_updown_counter_display.sv
// Multi-digit BCD up/down/clear counter on debounced buttons with a multiplexed seven-segment output.
module bcd_updown_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REFRESH_CYCLES  = 50000,
  parameter bit          BLANK_LZ        = 1'b1
) (
  input logic       clk,
  input logic       rst,
  bcd_disp_if.slave bus
);
  localparam int unsigned IDX_W = clog2(DIGITS);
  localparam int unsigned REF_W = clog2(REFRESH_CYCLES);
  localparam logic [DIGITS-1:0] ANODE_RST = ~DIGITS'(1);

  logic up_p, down_p, clr_p;

  pb_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .pb(bus.pb_up), .press(up_p)
  );
  pb_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .pb(bus.pb_down), .press(down_p)
  );
  pb_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst(rst), .pb(bus.pb_clr), .press(clr_p)
  );

  logic [DIGITS-1:0][3:0] count_q, count_inc, count_dec;
  logic                   inc_wrap, dec_wrap, wrap_q;
  bcd_step_t              step;
  logic                   carry, borrow;

  // Ripple carry/borrow chains; a carry out of the top digit is the wrap condition
  always_comb begin
    step      = '0;
    carry     = 1'b1;
    borrow    = 1'b1;
    count_inc = '0;
    count_dec = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      step         = bcd_inc(count_q[i], carry);
      count_inc[i] = step.digit;
      carry        = step.carry;
      step         = bcd_dec(count_q[i], borrow);
      count_dec[i] = step.digit;
      borrow       = step.carry;
    end
    inc_wrap = carry;
    dec_wrap = borrow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clr_p) begin
        count_q <= '0;
      end else if (up_p && !down_p) begin
        count_q <= count_inc;
        wrap_q  <= inc_wrap;
      end else if (down_p && !up_p) begin
        count_q <= count_dec;
        wrap_q  <= dec_wrap;
      end
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.wrap      = wrap_q;

  logic [REF_W-1:0]  ref_q;
  logic              ref_tc;
  logic [IDX_W-1:0]  idx_q, idx_next;
  logic [DIGITS-1:0] blank;
  logic              upper_zero;
  int unsigned       di;
  logic [3:0]        sel_digit;
  logic [6:0]        seg_code, display_next, display_q;
  logic [DIGITS-1:0] anode_next, anode_q;

  assign ref_tc = (ref_q == REF_W'(REFRESH_CYCLES - 1));

  // Outputs are computed from the upcoming index so anode and segments switch with it
  always_comb begin
    idx_next = idx_q;
    if (ref_tc) idx_next = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    blank      = '0;
    upper_zero = 1'b1;
    di         = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      di         = DIGITS - 1 - k;
      upper_zero = upper_zero && (count_q[di] == 4'd0);
      if (BLANK_LZ && di != 0) blank[di] = upper_zero;
    end

    sel_digit  = count_q[idx_next];
    anode_next = '1;
    if (!blank[idx_next]) anode_next[idx_next] = 1'b0;
    display_next = blank[idx_next] ? SEG_BLANK : seg_code;
  end

  bcd_to_seven_segment_decoder u_dec (
    .bcd(sel_digit),
    .seg(seg_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q     <= '0;
      idx_q     <= '0;
      anode_q   <= ANODE_RST;
      display_q <= bcd_seg(4'd0);
    end else begin
      ref_q     <= ref_tc ? '0 : ref_q + 1'b1;
      idx_q     <= idx_next;
      anode_q   <= anode_next;
      display_q <= display_next;
    end
  end

  assign bus.anode   = anode_q;
  assign bus.display = display_q;
endmodule

// File: tb/tb_bcd_updown_counter_display.sv
// Randomized press-level bench for the BCD counter/display, blanking on and off side by side.
module tb_bcd_updown_counter_display;
  localparam int unsigned D   = 2;
  localparam int unsigned DC  = 4;
  localparam int unsigned RC  = 3;
  localparam int          LAT = 2 + DC + 1;
  localparam int          MOD = 100;

  logic clk = 1'b0;
  logic rst;
  logic pb_up, pb_down, pb_clr;
  always #5 clk = ~clk;

  bcd_disp_if #(.DIGITS(D)) bus_b ();
  bcd_disp_if #(.DIGITS(D)) bus_n ();
  assign bus_b.pb_up = pb_up;  assign bus_b.pb_down = pb_down;  assign bus_b.pb_clr = pb_clr;
  assign bus_n.pb_up = pb_up;  assign bus_n.pb_down = pb_down;  assign bus_n.pb_clr = pb_clr;

  bcd_updown_counter_display #(
    .DIGITS(D), .DEBOUNCE_CYCLES(DC), .REFRESH_CYCLES(RC), .BLANK_LZ(1'b1)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  bcd_updown_counter_display #(
    .DIGITS(D), .DEBOUNCE_CYCLES(DC), .REFRESH_CYCLES(RC), .BLANK_LZ(1'b0)
  ) dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a press takes effect LAT edges after its raw edge; display shows the prior cycle's count
  int         edge_no = 0;
  int         exp_n = 0, prev_n = 0, t_ref = 0;
  bit         exp_wrap = 0;
  logic [2:0] ev [int];

  function automatic int p10(input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r *= 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < D; k++) r |= 32'((n / p10(k)) % 10) << (4 * k);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    string lit;
    logic [6:0] s = 7'h7F;
    case (d)
      0: lit = "abcdef";  1: lit = "bc";     2: lit = "abdeg";  3: lit = "abcdg";
      4: lit = "bcfg";    5: lit = "acdfg";  6: lit = "acdefg"; 7: lit = "abc";
      8: lit = "abcdefg"; default: lit = "abcdfg";
    endcase
    for (int i = 0; i < lit.len(); i++) s[lit[i] - "a"] = 1'b0;
    return s;
  endfunction

  task automatic model_edge();
    logic [2:0] e;
    edge_no++;
    prev_n   = exp_n;
    exp_wrap = 0;
    if (rst) begin
      exp_n = 0; prev_n = 0; t_ref = 0;
      ev.delete();
    end else begin
      t_ref++;
      if (ev.exists(edge_no)) begin
        e = ev[edge_no];
        ev.delete(edge_no);
        if (e[2]) exp_n = 0;
        else if (e[0] && e[1]) ;
        else if (e[0]) begin exp_wrap = (exp_n == MOD - 1); exp_n = (exp_n + 1) % MOD; end
        else if (e[1]) begin exp_wrap = (exp_n == 0); exp_n = (exp_n + MOD - 1) % MOD; end
      end
    end
  endtask

  task automatic check_outputs();
    int idx, upper;
    bit blank;
    logic [D-1:0] an;
    idx   = (t_ref / RC) % D;
    upper = prev_n / p10(idx);
    check("count_b", bus_b.count_bcd, to_bcd(exp_n));
    check("count_n", bus_n.count_bcd, to_bcd(exp_n));
    check("wrap_b", bus_b.wrap, exp_wrap);
    check("wrap_n", bus_n.wrap, exp_wrap);
    blank = (idx > 0) && (upper == 0);
    an = '1;
    if (!blank) an[idx] = 1'b0;
    check("anode_b", bus_b.anode, an);
    if (!blank) check("display_b", bus_b.display, seg_of(upper % 10));
    an = '1;
    an[idx] = 1'b0;
    check("anode_n", bus_n.anode, an);
    check("display_n", bus_n.display, seg_of(upper % 10));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_btn(input logic [2:0] b);
    pb_up = b[0]; pb_down = b[1]; pb_clr = b[2];
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    set_btn(b);
    ev[edge_no + LAT] = b;
    repeat (hold) cycle();
    set_btn(3'b000);
    repeat (DC + 6) cycle();
  endtask

  task automatic glitch(input logic [2:0] b, input int g);
    set_btn(b);
    repeat (g) cycle();
    set_btn(3'b000);
    repeat (DC + 4) cycle();
  endtask

  task automatic presses(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) press(b, DC + 1);
  endtask

  initial begin
    rst = 1'b1;
    set_btn(3'b001);
    repeat (2) cycle();
    rst = 1'b0;
    ev[edge_no + LAT] = 3'b001;
    repeat (12) cycle();
    set_btn(3'b000);
    repeat (DC + 6) cycle();

    press(3'b100, DC + 2);
    for (int i = 0; i < 5; i++) begin
      set_btn(3'b001); repeat (2) cycle();
      set_btn(3'b000); repeat (2) cycle();
    end
    press(3'b001, 10);

    press(3'b100, DC);
    presses(3'b001, 10);
    presses(3'b001, 89);
    press(3'b001, DC);

    press(3'b100, DC);
    press(3'b010, DC + 1);
    press(3'b100, DC);
    presses(3'b001, 10);
    press(3'b010, DC + 1);

    press(3'b100, DC);
    presses(3'b001, 5);
    press(3'b011, DC + 2);
    press(3'b101, DC + 2);

    presses(3'b001, 7);
    repeat (12) cycle();
    glitch(3'b001, DC - 1);
    glitch(3'b010, 1);

    for (int i = 0; i < 80; i++) begin
      int r = int'($urandom_range(0, 10));
      int h = int'($urandom_range(DC, DC + 6));
      case (r)
        0, 1, 2: press(3'b001, h);
        3, 4:    press(3'b010, h);
        5:       press(3'b011, h);
        6:       press((($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110), h);
        7:       press(3'b100, h);
        8:       glitch(3'b001 << $urandom_range(0, 2), int'($urandom_range(1, DC - 1)));
        9:       repeat (int'($urandom_range(1, 7))) cycle();
        default: begin
          rst = 1'b1;
          cycle();
          rst = 1'b0;
          repeat (DC) cycle();
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
